// File: rtl/tcdm_downcast_pkg.sv
// Shared types and elaboration helpers for the TCDM wide-to-narrow down-converter.
package tcdm_downcast_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCollect,
    StResp
  } state_e;

  function automatic int unsigned calc_ratio(int unsigned wide_w, int unsigned narrow_w);
    return wide_w / narrow_w;
  endfunction

  // Counters must be able to hold the value Ratio itself, hence the extra bit.
  function automatic int unsigned cnt_width(int unsigned ratio);
    return $clog2(ratio) + 1;
  endfunction

  function automatic bit is_pow2(int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/tcdm_downcast_if.sv
// TCDM request/response bundle; one instance per side of the converter.
interface tcdm_downcast_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64
);
  localparam int unsigned BeWidth = DataWidth / 8;

  logic                 req;
  logic                 gnt;
  logic [AddrWidth-1:0] addr;
  logic                 wen;
  logic [BeWidth-1:0]   be;
  logic [DataWidth-1:0] data;
  logic                 r_valid;
  logic                 r_ready;
  logic [DataWidth-1:0] r_data;

  modport master (
    output req, addr, wen, be, data, r_ready,
    input  gnt, r_valid, r_data
  );

  modport slave (
    input  req, addr, wen, be, data, r_ready,
    output gnt, r_valid, r_data
  );

endinterface

// File: rtl/tcdm_downcast.sv
// Serialises one wide TCDM op into Ratio narrow beats and reassembles read data.
module tcdm_downcast
  import tcdm_downcast_pkg::*;
#(
  parameter int unsigned WideWidth   = 64,
  parameter int unsigned NarrowWidth = 16,
  parameter int unsigned AddrWidth   = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  tcdm_downcast_if.slave  wide,
  tcdm_downcast_if.master narrow
);

  localparam int unsigned Ratio       = calc_ratio(WideWidth, NarrowWidth);
  localparam int unsigned CntWidth    = cnt_width(Ratio);
  localparam int unsigned IdxWidth    = CntWidth - 1;
  localparam int unsigned WideBytes   = WideWidth / 8;
  localparam int unsigned NarrowBytes = NarrowWidth / 8;
  localparam int unsigned NarrowShift = $clog2(NarrowBytes);
  localparam logic [CntWidth-1:0] RatioCnt = CntWidth'(Ratio);

  if (!is_pow2(WideWidth) || !is_pow2(NarrowWidth) || Ratio < 2) begin : g_bad_params
    $fatal(1, "tcdm_downcast: widths must be powers of two with WideWidth >= 2*NarrowWidth");
  end

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CntWidth-1:0]   rsp_cnt_q, rsp_cnt_d;
  logic [AddrWidth-1:0]  base_q, base_d;
  logic                  wen_q, wen_d;
  logic [WideBytes-1:0]  be_q, be_d;
  logic [WideWidth-1:0]  data_q, data_d;
  logic [WideWidth-1:0]  rdata_q, rdata_d;

  logic [IdxWidth-1:0]   beat_idx, rsp_idx;
  logic [CntWidth-1:0]   issue_next, rsp_cnt_inc;
  logic                  in_issue, n_fire, r_fire, issue_done;

  // First beat at or after `from` whose byte-enable slice is non-zero; Ratio if none remain.
  function automatic logic [CntWidth-1:0] next_wr_beat(logic [WideBytes-1:0] be,
                                                       logic [CntWidth-1:0]  from);
    logic [CntWidth-1:0] res;
    logic                found;
    res   = RatioCnt;
    found = 1'b0;
    for (int unsigned i = 0; i < Ratio; i++) begin
      if (!found && CntWidth'(i) >= from && |be[i*NarrowBytes +: NarrowBytes]) begin
        res   = CntWidth'(i);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign beat_idx    = issue_cnt_q[IdxWidth-1:0];
  assign rsp_idx     = rsp_cnt_q[IdxWidth-1:0];
  assign in_issue    = (state_q == StIssue);
  assign n_fire      = narrow.req & narrow.gnt;
  assign r_fire      = narrow.r_valid & narrow.r_ready;
  assign rsp_cnt_inc = rsp_cnt_q + {{(CntWidth-1){1'b0}}, r_fire};
  // Reads walk every beat; writes jump over beats with no enabled bytes.
  assign issue_next  = wen_q ? next_wr_beat(be_q, issue_cnt_q + CntWidth'(1))
                             : issue_cnt_q + CntWidth'(1);
  assign issue_done  = (issue_next == RatioCnt);

  assign wide.gnt     = (state_q == StIdle) & wide.req;
  assign wide.r_valid = (state_q == StResp);
  assign wide.r_data  = rdata_q;

  assign narrow.req     = in_issue;
  assign narrow.wen     = in_issue & wen_q;
  assign narrow.addr    = in_issue ? base_q + (AddrWidth'(beat_idx) << NarrowShift) : '0;
  assign narrow.be      = in_issue ? be_q[beat_idx*NarrowBytes +: NarrowBytes] : '0;
  assign narrow.data    = in_issue ? data_q[beat_idx*NarrowWidth +: NarrowWidth] : '0;
  assign narrow.r_ready = ((state_q == StIssue) || (state_q == StCollect)) &&
                          (rsp_cnt_q < RatioCnt);

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    rsp_cnt_d   = rsp_cnt_q;
    base_d      = base_q;
    wen_d       = wen_q;
    be_d        = be_q;
    data_d      = data_q;
    rdata_d     = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (wide.req) begin
          base_d      = wide.addr & ~AddrWidth'(WideBytes - 1);
          wen_d       = wide.wen;
          be_d        = wide.be;
          data_d      = wide.data;
          rsp_cnt_d   = '0;
          issue_cnt_d = wide.wen ? next_wr_beat(wide.be, '0) : '0;
          // A write with no enabled bytes is acknowledged without touching memory.
          if (!(wide.wen && (wide.be == '0))) begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (n_fire) begin
          issue_cnt_d = issue_next;
          if (issue_done) begin
            if (wen_q) begin
              state_d = StIdle;
            end else if (rsp_cnt_inc == RatioCnt) begin
              state_d = StResp;
            end else begin
              state_d = StCollect;
            end
          end
        end
      end
      StCollect: begin
        if (rsp_cnt_inc == RatioCnt) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (wide.r_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (r_fire) begin
      rdata_d[rsp_idx*NarrowWidth +: NarrowWidth] = narrow.r_data;
      rsp_cnt_d                                   = rsp_cnt_inc;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      issue_cnt_q <= '0;
      rsp_cnt_q   <= '0;
      base_q      <= '0;
      wen_q       <= 1'b0;
      be_q        <= '0;
      data_q      <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      rsp_cnt_q   <= rsp_cnt_d;
      base_q      <= base_d;
      wen_q       <= wen_d;
      be_q        <= be_d;
      data_q      <= data_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_tcdm_downcast.sv
// Bench for tcdm_downcast: byte-level reference memory, narrow target model, random stalls.
module tb_tcdm_downcast;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [1:0]  be;
    logic [15:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tcdm_downcast_if #(.AddrWidth(32), .DataWidth(64)) wide_bus ();
  tcdm_downcast_if #(.AddrWidth(32), .DataWidth(16)) narrow_bus ();

  tcdm_downcast #(
    .WideWidth  (64),
    .NarrowWidth(16),
    .AddrWidth  (32)
  ) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .wide  (wide_bus),
    .narrow(narrow_bus)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_mis = 0;
  int          cyc = 0;
  int          beats_fired = 0;
  bit          stall_mode = 1'b0;
  beat_t       exp_q[$];
  int          gnt_cyc_q[$];
  logic [7:0]  ref_mem[int];
  logic [15:0] mem16[int];
  logic [15:0] rsp_data_q[$];
  int          rsp_time_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref_read(input logic [31:0] base);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) begin
      r[8*i +: 8] = ref_mem.exists(int'(base) + i) ? ref_mem[int'(base) + i] : 8'h00;
    end
    return r;
  endfunction

  // Reference behaviour: aligned base, four 16-bit beats; writes drop beats with no enabled bytes.
  task automatic model_accept(input logic [31:0] a, input logic wen, input logic [7:0] be,
                              input logic [63:0] d);
    logic [31:0] base;
    beat_t       b;
    base = a & ~32'h7;
    for (int k = 0; k < 4; k++) begin
      b.addr = base + 32'(2 * k);
      b.wen  = wen;
      b.be   = be[2*k +: 2];
      b.data = d[16*k +: 16];
      if (!wen || b.be != 2'b00) exp_q.push_back(b);
    end
    if (wen) begin
      for (int i = 0; i < 8; i++) begin
        if (be[i]) ref_mem[int'(base) + i] = d[8*i +: 8];
      end
    end
  endtask

  // Narrow target: random grant stalls, in-order read data with random latency.
  initial begin : narrow_target
    bit          stalled_prev;
    logic [63:0] held;
    int          last_rdy;
    beat_t       e;
    int          widx;
    logic [15:0] w;
    stalled_prev = 1'b0;
    last_rdy     = 0;
    narrow_bus.gnt     = 1'b0;
    narrow_bus.r_valid = 1'b0;
    narrow_bus.r_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        rsp_data_q.delete();
        rsp_time_q.delete();
        narrow_bus.gnt     = 1'b0;
        narrow_bus.r_valid = 1'b0;
        narrow_bus.r_data  = '0;
        stalled_prev       = 1'b0;
        continue;
      end
      narrow_bus.gnt = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (rsp_data_q.size() > 0 && rsp_time_q[0] <= cyc) begin
        narrow_bus.r_valid = 1'b1;
        narrow_bus.r_data  = rsp_data_q[0];
      end else begin
        narrow_bus.r_valid = 1'b0;
        narrow_bus.r_data  = '0;
      end
      @(negedge clk);
      if (rst) begin
        stalled_prev = 1'b0;
        continue;
      end
      if (stalled_prev) begin
        check_eq("n_req_held", 64'(narrow_bus.req), 64'd1);
        check_eq("n_payload_held", 64'({narrow_bus.addr, narrow_bus.wen, narrow_bus.be,
                                         narrow_bus.data}), held);
      end
      stalled_prev = narrow_bus.req && !narrow_bus.gnt;
      held = 64'({narrow_bus.addr, narrow_bus.wen, narrow_bus.be, narrow_bus.data});
      if (narrow_bus.req && narrow_bus.gnt) begin
        gnt_cyc_q.push_back(cyc);
        beats_fired++;
        check_eq("beat_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("n_addr", 64'(narrow_bus.addr), 64'(e.addr));
          check_eq("n_wen", 64'(narrow_bus.wen), 64'(e.wen));
          check_eq("n_be", 64'(narrow_bus.be), 64'(e.be));
          if (e.wen) check_eq("n_data", 64'(narrow_bus.data), 64'(e.data));
        end
        widx = int'(narrow_bus.addr >> 1);
        w = mem16.exists(widx) ? mem16[widx] : 16'h0000;
        if (narrow_bus.wen) begin
          if (narrow_bus.be[0]) w[7:0] = narrow_bus.data[7:0];
          if (narrow_bus.be[1]) w[15:8] = narrow_bus.data[15:8];
          mem16[widx] = w;
        end else begin
          last_rdy = (last_rdy > cyc + 1) ? last_rdy : cyc + 1;
          if (stall_mode) last_rdy += int'($urandom_range(0, 3));
          rsp_data_q.push_back(w);
          rsp_time_q.push_back(last_rdy);
        end
      end
      if (narrow_bus.r_valid && narrow_bus.r_ready && rsp_data_q.size() > 0) begin
        void'(rsp_data_q.pop_front());
        void'(rsp_time_q.pop_front());
      end
    end
  end

  task automatic accept(input logic [31:0] a, input logic wen, input logic [7:0] be,
                        input logic [63:0] d, output int acc, output int waited);
    bit seen;
    seen   = 1'b0;
    acc    = -1;
    waited = 0;
    @(posedge clk);
    #2;
    wide_bus.req  = 1'b1;
    wide_bus.addr = a;
    wide_bus.wen  = wen;
    wide_bus.be   = be;
    wide_bus.data = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wide_bus.gnt) begin
        seen = 1'b1;
        break;
      end
      waited++;
    end
    check_eq("w_gnt_seen", 64'(seen), 64'd1);
    if (seen) begin
      acc = cyc;
      model_accept(a, wen, be, d);
    end
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check_eq("beats_drained", 64'(done), 64'd1);
  endtask

  task automatic do_op(input logic [31:0] a, input logic wen, input logic [7:0] be,
                       input logic [63:0] d, input int rdy_delay, output int acc, output int rv,
                       output logic [63:0] rdata);
    int          waited;
    bit          seen;
    logic [63:0] exp;
    rv    = -1;
    rdata = '0;
    exp   = ref_read(a & ~32'h7);
    accept(a, wen, be, d, acc, waited);
    @(posedge clk);
    #2;
    wide_bus.req = 1'b0;
    if (wen) begin
      wait_drain();
    end else begin
      seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (wide_bus.r_valid) begin
          seen = 1'b1;
          break;
        end
      end
      check_eq("w_r_valid_seen", 64'(seen), 64'd1);
      rv    = cyc;
      rdata = wide_bus.r_data;
      check_eq("w_r_data", wide_bus.r_data, exp);
      repeat (rdy_delay) begin
        @(negedge clk);
        check_eq("w_r_valid_held", 64'(wide_bus.r_valid), 64'd1);
        check_eq("w_r_data_held", wide_bus.r_data, exp);
      end
      wide_bus.r_ready = 1'b1;
      @(posedge clk);
      #2;
      wide_bus.r_ready = 1'b0;
      @(negedge clk);
      check_eq("w_r_valid_drop", 64'(wide_bus.r_valid), 64'd0);
      check_eq("beats_left", 64'(exp_q.size()), 64'd0);
    end
  endtask

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          acc0, acc1, acc2, acc3, acc4, waited, rv, nb;
    logic [63:0] rd, rd_aligned;
    logic [31:0] ra;
    logic [7:0]  rbe;
    int          r;
    bit          ok;

    wide_bus.req     = 1'b0;
    wide_bus.addr    = '0;
    wide_bus.wen     = 1'b0;
    wide_bus.be      = '0;
    wide_bus.data    = '0;
    wide_bus.r_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("rst_w_gnt_rvalid", 64'({wide_bus.gnt, wide_bus.r_valid}), 64'd0);
    check_eq("rst_w_r_data", wide_bus.r_data, 64'd0);
    check_eq("rst_n_ctrl", 64'({narrow_bus.req, narrow_bus.wen, narrow_bus.r_ready}), 64'd0);
    check_eq("rst_n_payload", 64'({narrow_bus.addr, narrow_bus.be, narrow_bus.data}), 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Zero-wait target: full write, back-to-back accepts, partial and empty byte enables.
    stall_mode = 1'b0;
    gnt_cyc_q.delete();
    accept(32'h08, 1'b1, 8'hFF, 64'h0003_0002_0001_0000, acc0, waited);
    check_eq("wr_gnt_cycle0", 64'(waited), 64'd0);
    accept(32'h10, 1'b1, 8'hFF, 64'h1111_2222_3333_4444, acc1, waited);
    check_eq("wr_free_latency", 64'(acc1 - acc0), 64'd5);
    for (int k = 0; k < 4; k++) begin
      check_eq("wr_beat_cycle", 64'(gnt_cyc_q[k] - acc0), 64'(k + 1));
    end
    accept(32'h08, 1'b1, 8'h0C, 64'hAAAA_BBBB_CCCC_DDDD, acc2, waited);
    nb = beats_fired;
    accept(32'h30, 1'b1, 8'h00, 64'hDEAD_BEEF_DEAD_BEEF, acc3, waited);
    check_eq("wr_partial_latency", 64'(acc3 - acc2), 64'd2);
    check_eq("wr_partial_one_beat", 64'(beats_fired - nb), 64'd1);
    accept(32'h38, 1'b1, 8'hFF, 64'h0123_4567_89AB_CDEF, acc4, waited);
    check_eq("wr_empty_latency", 64'(acc4 - acc3), 64'd1);
    @(posedge clk);
    #2;
    wide_bus.req = 1'b0;
    wait_drain();

    // Preloaded read, pipelined zero-wait timing, then unaligned address.
    for (int k = 0; k < 4; k++) begin
      mem16[4 + k]        = 16'h0010 + 16'(k);
      ref_mem[8 + 2*k]    = 8'h10 + 8'(k);
      ref_mem[8 + 2*k + 1] = 8'h00;
    end
    do_op(32'h08, 1'b0, 8'hFF, 64'h0, 0, acc0, rv, rd);
    check_eq("rd_latency", 64'(rv - acc0), 64'd6);
    check_eq("rd_data_const", rd, 64'h0013_0012_0011_0010);
    do_op(32'h0B, 1'b0, 8'h00, 64'h0, 2, acc0, rv, rd);
    check_eq("rd_unaligned", rd, 64'h0013_0012_0011_0010);

    // Random traffic against stalling target and slow upstream.
    stall_mode = 1'b1;
    do_op(32'h08, 1'b0, 8'hFF, 64'h0, 5, acc0, rv, rd);
    check_eq("rd_stall_data", rd, 64'h0013_0012_0011_0010);
    for (int n = 0; n < 60; n++) begin
      ra  = 32'($urandom_range(0, 63));
      r   = int'($urandom_range(0, 5));
      rbe = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
      do_op(ra, 1'($urandom), rbe, {$urandom, $urandom}, int'($urandom_range(0, 5)), acc0, rv,
            rd);
    end
    // Aligned and unaligned reads of the same block must agree.
    do_op(32'h21, 1'b0, 8'hFF, 64'h0, 1, acc0, rv, rd);
    do_op(32'h20, 1'b0, 8'hFF, 64'h0, 0, acc0, rv, rd_aligned);
    check_eq("rd_alias", rd, rd_aligned);

    // Reset in the middle of a read.
    stall_mode = 1'b0;
    nb = beats_fired;
    accept(32'h08, 1'b0, 8'hFF, 64'h0, acc0, waited);
    @(posedge clk);
    #2;
    wide_bus.req = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (beats_fired - nb >= 2) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #2;
    end
    check_eq("rst_two_beats_seen", 64'(ok), 64'd1);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_eq("midrst_w_ctrl", 64'({wide_bus.gnt, wide_bus.r_valid}), 64'd0);
    check_eq("midrst_w_r_data", wide_bus.r_data, 64'd0);
    check_eq("midrst_n_ctrl", 64'({narrow_bus.req, narrow_bus.wen, narrow_bus.r_ready}), 64'd0);
    check_eq("midrst_n_payload", 64'({narrow_bus.addr, narrow_bus.be, narrow_bus.data}), 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    do_op(32'h08, 1'b0, 8'hFF, 64'h0, 0, acc0, rv, rd);
    check_eq("post_rst_rd_latency", 64'(rv - acc0), 64'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
